// File: rtl/seq_shift_pkg.sv
// Shared types for the multi-cycle shift/rotate engine (seq_shift_unit).
package seq_shift_pkg;

  typedef enum logic [2:0] {
    SH_PASS = 3'b000,
    SH_LSL  = 3'b001,
    SH_ASL  = 3'b010,
    SH_LSR  = 3'b011,
    SH_ASR  = 3'b100,
    SH_ROL  = 3'b101,
    SH_ROR  = 3'b110,
    SH_RSVD = 3'b111
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_pass_mode(input shift_mode_e mode);
    return (mode == SH_PASS) || (mode == SH_RSVD);
  endfunction

endpackage

// File: rtl/seq_shift_unit_step.sv
// One-position shift/rotate datapath for seq_shift_unit; purely combinational.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result,
  output logic             sign_changed
);

  always_comb begin
    result = data;
    unique case (mode)
      SH_LSL, SH_ASL: result = {data[WIDTH-2:0], 1'b0};
      SH_LSR:         result = {1'b0, data[WIDTH-1:1]};
      SH_ASR:         result = {data[WIDTH-1], data[WIDTH-1:1]};
      SH_ROL:         result = {data[WIDTH-2:0], data[WIDTH-1]};
      SH_ROR:         result = {data[0], data[WIDTH-1:1]};
      default:        result = data;
    endcase
  end

  assign sign_changed = result[WIDTH-1] ^ data[WIDTH-1];

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine, one bit position per clock, valid/ready on both sides.
// Optional ASL overflow flag enabled by defining SEQ_SHIFT_OVF_EN.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] d_in,
  input  logic [2:0]              sel,
  input  logic [CNT_W-1:0]        shift_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] d_out,
  output logic                    busy,
  output logic                    ovf
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and d_out is stable there.

  shift_state_e     state;
  shift_mode_e      mode_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] step_result;
  shift_mode_e      sel_mode;

  assign sel_mode = shift_mode_e'(sel);

`ifdef SEQ_SHIFT_OVF_EN
  logic step_sign_changed;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data         (data_q),
    .mode         (mode_q),
    .result       (step_result),
`ifdef SEQ_SHIFT_OVF_EN
    .sign_changed (step_sign_changed)
`else
    .sign_changed ()
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= SH_PASS;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q <= d_in;
            mode_q <= sel_mode;
            cnt_q  <= shift_count;
            if ((shift_count == '0) || is_pass_mode(sel_mode)) state <= ST_DONE;
            else                                                 state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q <= step_result;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_SHIFT_OVF_EN
  logic ovf_q;

  // Sticky over the whole operation; only ASL steps can raise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      ovf_q <= 1'b0;
    end else if (state == ST_SHIFT && mode_q == SH_ASL && step_sign_changed) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign d_out     = data_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit at WIDTH=8; honours SEQ_SHIFT_OVF_EN for the ovf expectations.
module tb_seq_shift_unit;

  localparam int W     = 8;
  localparam int CW    = $clog2(W) + 1;
  localparam int LIMIT = 200;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] d_in = '0;
  logic [2:0]          sel = '0;
  logic [CW-1:0]       shift_count = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] d_out;
  logic                busy;
  logic                ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  seq_shift_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .d_in        (d_in),
    .sel         (sel),
    .shift_count (shift_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_out       (d_out),
    .busy        (busy),
    .ovf         (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_result(input logic [W-1:0] d, input logic [2:0] s, input int n);
    logic signed [W-1:0] sd;
    int r;
    sd = d;
    r  = n % W;
    case (s)
      3'd1, 3'd2: return (n >= W) ? '0 : W'(d << n);
      3'd3:       return (n >= W) ? '0 : W'(d >> n);
      3'd4:       return (n >= W) ? {W{d[W-1]}} : W'(sd >>> n);
      3'd5:       return (r == 0) ? d : W'((d << r) | (d >> (W - r)));
      3'd6:       return (r == 0) ? d : W'((d >> r) | (d << (W - r)));
      default:    return d;
    endcase
  endfunction

  // Overflow means the true product d * 2^n does not fit in a signed W-bit word.
  function automatic logic model_ovf(input logic [W-1:0] d, input logic [2:0] s, input int n);
`ifdef SEQ_SHIFT_OVF_EN
    longint v;
    logic signed [W-1:0] sd;
    sd = d;
    v  = longint'(sd) * (longint'(1) << n);
    return (s == 3'd2) && (v < -(longint'(1) << (W-1)) || v > ((longint'(1) << (W-1)) - 1));
`else
    return (d == d) && (s == s) && (n == n) ? 1'b0 : 1'b0;
`endif
  endfunction

  function automatic int model_latency(input logic [2:0] s, input int n);
    return (s == 3'd0 || s == 3'd7) ? 0 : n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] d, input logic [2:0] s, input int n);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < LIMIT) begin
      tick();
      waited++;
    end
    if (waited >= LIMIT) begin
      tests_run++;
      tests_failed++;
      $display("FAIL start_op_timeout in_ready=%b required=1", in_ready);
    end
    d_in        = d;
    sel         = s;
    shift_count = CW'(n);
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    d_in        = W'($urandom);
    sel         = 3'($urandom);
    shift_count = CW'($urandom);
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Full operation, scored against the model through exp_q.
  task automatic run_checked(input string name, input logic [W-1:0] d, input logic [2:0] s, input int n);
    int lat;
    bit busy_ok;
    logic [W-1:0] exp_d;
    logic exp_ovf;
    exp_q.push_back(model_result(d, s, n));
    exp_ovf = model_ovf(d, s, n);
    start_op(d, s, n);
    wait_valid(lat, busy_ok);
    exp_d = exp_q.pop_front();
    tests_run++;
    if (d_out !== exp_d) begin
      tests_failed++;
      $display("FAIL %s d_out d=%h sel=%0d n=%0d got=%h required=%h", name, d, s, n, d_out, exp_d);
    end
    tests_run++;
    if (lat !== model_latency(s, n)) begin
      tests_failed++;
      $display("FAIL %s latency got=%0d required=%0d", name, lat, model_latency(s, n));
    end
    tests_run++;
    if (ovf !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s ovf d=%h sel=%0d n=%0d got=%b required=%b", name, d, s, n, ovf, exp_ovf);
    end
    tests_run++;
    if (!busy_ok) begin
      tests_failed++;
      $display("FAIL %s busy got=0 required=1 while operating", name);
    end
    take_result();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s handshake out_valid=%b in_ready=%b required=0/1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(3);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || d_out !== '0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset in_ready=%b out_valid=%b busy=%b d_out=%h ovf=%b required=1/0/0/00/0",
               in_ready, out_valid, busy, d_out, ovf);
    end
  endtask

  task automatic test_directed();
    run_checked("asr_b4_3",  8'hB4, 3'd4, 3);
    run_checked("rol_b4_3",  8'hB4, 3'd5, 3);
    run_checked("ror_81_10", 8'h81, 3'd6, 10);
    run_checked("lsr_5a_0",  8'h5A, 3'd3, 0);
    run_checked("lsl_5a_12", 8'h5A, 3'd1, 12);
    run_checked("asr_80_15", 8'h80, 3'd4, 15);
    run_checked("pass_rsvd", 8'h3C, 3'd7, 9);
    tests_run++;
    if (model_result(8'hB4, 3'd4, 3) !== 8'hF6 || model_result(8'h81, 3'd6, 10) !== 8'h60) begin
      tests_failed++;
      $display("FAIL model_sanity asr=%h ror=%h required=f6/60",
               model_result(8'hB4, 3'd4, 3), model_result(8'h81, 3'd6, 10));
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit busy_ok;
    logic [W-1:0] held;
    start_op(8'hC3, 3'd5, 4);
    wait_valid(lat, busy_ok);
    held = d_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      d_in     = W'($urandom);
      sel      = 3'($urandom_range(1, 6));
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d_out !== held) begin
        tests_failed++;
        $display("FAIL backpressure cyc=%0d out_valid=%b in_ready=%b d_out=%h required=1/0/%h",
                 i, out_valid, in_ready, d_out, held);
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (held !== model_result(8'hC3, 3'd5, 4)) begin
      tests_failed++;
      $display("FAIL backpressure_result got=%h required=%h", held, model_result(8'hC3, 3'd5, 4));
    end
    // in_valid held high across the handshake edge must not be accepted on that edge
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_accept_on_handshake in_ready=%b busy=%b required=1/0", in_ready, busy);
    end
  endtask

  task automatic test_ovf();
    run_checked("asl_40_1", 8'h40, 3'd2, 1);
    run_checked("asl_20_1", 8'h20, 3'd2, 1);
    run_checked("asl_e0_2", 8'hE0, 3'd2, 2);
    run_checked("lsl_40_1", 8'h40, 3'd1, 1);
  endtask

  task automatic test_reset_midshift();
    start_op(8'h96, 3'd1, 8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || d_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midshift busy=%b d_out=%h out_valid=%b in_ready=%b ovf=%b required=0/00/0/1/0",
               busy, d_out, out_valid, in_ready, ovf);
    end
    run_checked("after_reset", 8'h96, 3'd4, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_checked("random", W'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ovf();
    test_reset_midshift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
